// File: rtl/cpu_prog_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cpu_prog_sequencer_if
//  Purpose  : Program-load, start and CPU handshake bundle for cpu_prog_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface cpu_prog_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [15:0]       prog_data;
    logic [ADDR_W:0]   prog_len;
    logic              go;
    logic              cpu_w;
    logic [15:0]       cpu_out;
    logic              cpu_N;
    logic              cpu_V;
    logic              cpu_Z;
    logic [15:0]       cpu_in;
    logic              cpu_load;
    logic              cpu_s;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic [15:0]       result;
    logic [2:0]        result_flags;
    logic              result_valid;
    logic              done;
    logic              err;

    modport master (
        output prog_we, prog_addr, prog_data, prog_len, go,
        output cpu_w, cpu_out, cpu_N, cpu_V, cpu_Z,
        input  cpu_in, cpu_load, cpu_s, pc, busy,
        input  result, result_flags, result_valid, done, err
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len, go,
        input  cpu_w, cpu_out, cpu_N, cpu_V, cpu_Z,
        output cpu_in, cpu_load, cpu_s, pc, busy,
        output result, result_flags, result_valid, done, err
    );
endinterface
`default_nettype wire

// File: rtl/cpu_prog_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cpu_prog_sequencer
//  Purpose  : Feeds a buffered program to the lab CPU one instruction at a
//             time and captures each instruction's result and flags.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_prog_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  wire logic            clk,
    input  wire logic            reset,
    cpu_prog_sequencer_if.slave  bus
);
    localparam int c_timer_w = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0]    c_depth   = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_timer_w:0] c_timeout = (c_timer_w + 1)'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_ACK   = 3'd3,
        S_RUN   = 3'd4,
        S_CAPT  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W:0]      r_len;
    logic [c_timer_w-1:0] r_timer;
    logic [15:0]          r_result;
    logic [2:0]           r_flags;
    logic [15:0]          r_cpu_in;
    logic [15:0]          r_mem [DEPTH];

    logic                 w_addr_ok;
    logic                 w_we;
    logic [ADDR_W:0]      w_len_clamped;
    logic [ADDR_W-1:0]    w_pc_next;
    logic                 w_last;
    logic                 w_timeout;

    generate
        if (DEPTH == (2 ** ADDR_W)) begin : g_addr_full
            assign w_addr_ok = 1'b1;
        end else begin : g_addr_part
            assign w_addr_ok = ({1'b0, bus.prog_addr} < c_depth);
        end
    endgenerate

    // Program buffer is only writable while no program is in flight.
    assign w_we          = bus.prog_we & w_addr_ok & ((r_state == S_IDLE) || (r_state == S_ERR));
    assign w_len_clamped = (bus.prog_len > c_depth) ? c_depth : bus.prog_len;
    assign w_pc_next     = r_pc + ADDR_W'(1);
    assign w_last        = (({1'b0, r_pc} + (ADDR_W + 1)'(1)) == r_len);
    // Trips on the cycle in which the timer would reach TIMEOUT.
    assign w_timeout     = (({1'b0, r_timer} + (c_timer_w + 1)'(1)) == c_timeout);

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_len    <= '0;
            r_timer  <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_cpu_in <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.go && bus.cpu_w) begin
                        r_len <= w_len_clamped;
                        r_pc  <= '0;
                        if (w_len_clamped == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cpu_in <= r_mem[0];
                            r_state  <= S_LOAD;
                        end
                    end
                end
                S_LOAD:  r_state <= S_START;
                S_START: begin
                    r_timer <= '0;
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    r_timer <= r_timer + c_timer_w'(1);
                    if (w_timeout) begin
                        r_state <= S_ERR;
                    end else if (!bus.cpu_w) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_timer <= r_timer + c_timer_w'(1);
                    if (w_timeout) begin
                        r_state <= S_ERR;
                    end else if (bus.cpu_w) begin
                        r_result <= bus.cpu_out;
                        r_flags  <= {bus.cpu_N, bus.cpu_V, bus.cpu_Z};
                        r_state  <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_pc     <= w_pc_next;
                        r_cpu_in <= r_mem[w_pc_next];
                        r_state  <= S_LOAD;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cpu_in       = r_cpu_in;
    assign bus.cpu_load     = (r_state == S_LOAD);
    assign bus.cpu_s        = (r_state == S_START);
    assign bus.pc           = r_pc;
    assign bus.busy         = (r_state != S_IDLE) && (r_state != S_ERR);
    assign bus.result       = r_result;
    assign bus.result_flags = r_flags;
    assign bus.result_valid = (r_state == S_CAPT);
    assign bus.done         = (r_state == S_DONE);
    assign bus.err          = (r_state == S_ERR);
endmodule
`default_nettype wire

// File: tb/tb_cpu_prog_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_prog_sequencer
//  Purpose  : Directed self-checking bench with a small behavioural lab-CPU model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_prog_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_prog_sequencer_if #(.ADDR_W(4)) bus();

    cpu_prog_sequencer #(.ADDR_W(4), .DEPTH(16), .TIMEOUT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // CPU model: idles with w=1, drops w after s, executes 3 cycles later.
    logic        m_w;
    logic [1:0]  m_cnt;
    logic [15:0] m_ir;
    logic [15:0] m_r [8];
    logic [15:0] m_out;
    logic [2:0]  m_nvz;
    logic        stub_hold   = 1'b0;
    logic        force_w_low = 1'b0;
    logic [15:0] m_a, m_b, m_sum, m_diff;

    assign m_a    = m_r[m_ir[10:8]];
    assign m_b    = m_r[m_ir[2:0]];
    assign m_sum  = m_a + m_b;
    assign m_diff = m_a - m_b;

    assign bus.cpu_w   = m_w & ~force_w_low;
    assign bus.cpu_out = m_out;
    assign bus.cpu_N   = m_nvz[2];
    assign bus.cpu_V   = m_nvz[1];
    assign bus.cpu_Z   = m_nvz[0];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_w   <= 1'b1;
            m_cnt <= 2'd0;
            m_ir  <= 16'h0;
            m_out <= 16'h0;
            m_nvz <= 3'b000;
            for (int i = 0; i < 8; i++) m_r[i] <= 16'h0;
        end else begin
            if (bus.cpu_load) m_ir <= bus.cpu_in;
            if (m_w) begin
                if (bus.cpu_s && !stub_hold) begin
                    m_w   <= 1'b0;
                    m_cnt <= 2'd2;
                end
            end else if (m_cnt != 2'd0) begin
                m_cnt <= m_cnt - 2'd1;
            end else begin
                m_w <= 1'b1;
                case (m_ir[15:11])
                    5'b11010: m_r[m_ir[10:8]] <= {{8{m_ir[7]}}, m_ir[7:0]};
                    5'b10100: begin
                        m_r[m_ir[7:5]] <= m_sum;
                        m_out          <= m_sum;
                    end
                    5'b10101: m_nvz <= {m_diff[15],
                                        (m_a[15] != m_b[15]) && (m_diff[15] != m_a[15]),
                                        (m_diff == 16'h0)};
                    default: ;
                endcase
            end
        end
    end

    // Event monitor, sampled mid-cycle.
    int          cyc = 0, n_rv = 0, n_done = 0, n_load = 0, n_s = 0;
    int          rv_cyc = 0, done_cyc = 0;
    logic [15:0] last_res = 16'h0, load0_in = 16'h0, load1_in = 16'h0;
    logic [2:0]  last_flags = 3'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.result_valid) begin
            n_rv       <= n_rv + 1;
            last_res   <= bus.result;
            last_flags <= bus.result_flags;
            rv_cyc     <= cyc;
        end
        if (bus.done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (bus.cpu_load) begin
            n_load <= n_load + 1;
            if (bus.pc == 4'd0) load0_in <= bus.cpu_in;
            if (bus.pc == 4'd1) load1_in <= bus.cpu_in;
        end
        if (bus.cpu_s) n_s <= n_s + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [15:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        tick(1);
        bus.prog_we   = 1'b0;
    endtask

    task automatic pulse_go(input logic [4:0] len);
        bus.prog_len = len;
        bus.go       = 1'b1;
        tick(1);
        bus.go       = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!bus.done && n < 200) begin
            tick(1);
            n++;
        end
        check_eq(tag, {31'd0, bus.done}, 32'd1);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!bus.cpu_s && n < 200) begin
            tick(1);
            n++;
        end
        check_eq(tag, {31'd0, bus.cpu_s}, 32'd1);
    endtask

    int s_rv, s_done, s_load, s_s, n;

    initial begin
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
        bus.prog_len = '0;  bus.go = 1'b0;
        reset = 1'b1;
        tick(2);
        check_eq("rst_ctl", {26'd0, bus.cpu_load, bus.cpu_s, bus.busy, bus.result_valid, bus.done, bus.err}, 32'd0);
        check_eq("rst_data", {bus.cpu_in, bus.result}, 32'd0);
        check_eq("rst_pc_flags", {25'd0, bus.pc, bus.result_flags}, 32'd0);
        reset = 1'b0;
        tick(1);

        // Three-instruction program: R2 = 2 + 7.
        prog_write(4'd0, 16'hD007);
        prog_write(4'd1, 16'hD102);
        prog_write(4'd2, 16'hA140);
        s_rv = n_rv; s_done = n_done; s_load = n_load; s_s = n_s;
        pulse_go(5'd3);
        wait_done("prog_done_seen");
        check_eq("prog_pc_at_done", {28'd0, bus.pc}, 32'd2);
        tick(2);
        check_eq("prog_rv_count", n_rv - s_rv, 3);
        check_eq("prog_load_count", n_load - s_load, 3);
        check_eq("prog_s_count", n_s - s_s, 3);
        check_eq("prog_done_count", n_done - s_done, 1);
        check_eq("prog_result", {16'd0, last_res}, 32'h0009);
        check_eq("prog_flags", {29'd0, last_flags}, 32'd0);
        check_eq("prog_done_after_capt", done_cyc - rv_cyc, 1);

        // Zero flag from CMP R0,R0.
        prog_write(4'd0, 16'hD005);
        prog_write(4'd1, 16'hA800);
        s_rv = n_rv;
        pulse_go(5'd2);
        wait_done("zflag_done_seen");
        tick(2);
        check_eq("zflag_rv_count", n_rv - s_rv, 2);
        check_eq("zflag_flags", {29'd0, last_flags}, 32'd1);

        // Empty run.
        s_done = n_done; s_load = n_load;
        bus.prog_len = 5'd0;
        bus.go = 1'b1;
        tick(1);
        check_eq("empty_done_next", {31'd0, bus.done}, 32'd1);
        bus.go = 1'b0;
        tick(2);
        check_eq("empty_no_load", n_load - s_load, 0);
        check_eq("empty_done_count", n_done - s_done, 1);

        // go ignored while the CPU is not waiting.
        force_w_low = 1'b1;
        s_load = n_load; s_done = n_done;
        bus.prog_len = 5'd2;
        bus.go = 1'b1;
        tick(3);
        check_eq("gate_busy", {31'd0, bus.busy}, 32'd0);
        bus.go = 1'b0;
        force_w_low = 1'b0;
        tick(2);
        check_eq("gate_no_load", n_load - s_load, 0);
        check_eq("gate_no_done", n_done - s_done, 0);

        // Write lockout during RUN.
        prog_write(4'd0, 16'hD007);
        prog_write(4'd1, 16'hD102);
        pulse_go(5'd2);
        wait_start("lock_start_seen");
        tick(2);
        check_eq("lock_busy_in_run", {31'd0, bus.busy}, 32'd1);
        prog_write(4'd1, 16'hFFFF);
        wait_done("lock_done1_seen");
        tick(1);
        pulse_go(5'd2);
        wait_done("lock_done2_seen");
        tick(2);
        check_eq("lock_pc1_instr", {16'd0, load1_in}, 32'h0000D102);

        // Asynchronous reset mid-RUN of the second instruction.
        pulse_go(5'd2);
        wait_start("arst_start0_seen");
        tick(1);
        wait_start("arst_start1_seen");
        tick(2);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_ctl", {26'd0, bus.cpu_load, bus.cpu_s, bus.busy, bus.result_valid, bus.done, bus.err}, 32'd0);
        check_eq("arst_data", {bus.cpu_in, bus.result}, 32'd0);
        check_eq("arst_pc_flags", {25'd0, bus.pc, bus.result_flags}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        s_rv = n_rv;
        pulse_go(5'd2);
        wait_done("arst_rerun_done");
        tick(2);
        check_eq("arst_rerun_rv", n_rv - s_rv, 2);
        check_eq("arst_pc0_instr", {16'd0, load0_in}, 32'h0000D007);
        check_eq("arst_pc1_instr", {16'd0, load1_in}, 32'h0000D102);

        // Handshake timeout with a CPU that never leaves its wait state.
        stub_hold = 1'b1;
        s_load = n_load;
        pulse_go(5'd1);
        wait_start("tmo_start_seen");
        n = 0;
        while (!bus.err && n < 50) begin
            tick(1);
            n++;
        end
        check_eq("tmo_cycles", n, 11);
        check_eq("tmo_busy", {31'd0, bus.busy}, 32'd0);
        pulse_go(5'd1);
        tick(3);
        check_eq("tmo_err_sticky", {31'd0, bus.err}, 32'd1);
        check_eq("tmo_go_ignored", n_load - s_load, 1);
        reset = 1'b1;
        tick(1);
        check_eq("tmo_err_cleared", {31'd0, bus.err}, 32'd0);
        reset = 1'b0;
        stub_hold = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
`default_nettype wire
